// File: rtl/bias_activation_seq_pkg.sv
// Shared float32 constants, FSM encodings and float helpers for the bias/activation stages.
// fp_add is the float adder: round-to-nearest-even, denormal inputs and underflowing results flush to zero.
package bias_activation_seq_pkg;

    localparam int          FLOAT_W       = 32;
    localparam logic [31:0] FLOAT_ZERO    = 32'h0000_0000;
    localparam logic [7:0]  FLOAT_EXP_MAX = 8'hFF;
    localparam logic [31:0] FLOAT_QNAN    = 32'h7FC0_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == FLOAT_EXP_MAX) && (f[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_inf;
        logic        b_inf;
        logic        a_zero;
        logic        b_zero;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic [7:0]  ed;
        logic [26:0] mx;
        logic [26:0] my;
        logic [26:0] my_sh;
        logic [26:0] lost_mask;
        logic [27:0] s;
        logic [9:0]  e;
        logic        rnd_up;
        logic [24:0] m_rnd;
        logic [22:0] frac;

        a_inf     = (a[30:23] == FLOAT_EXP_MAX) && (a[22:0] == 23'd0);
        b_inf     = (b[30:23] == FLOAT_EXP_MAX) && (b[22:0] == 23'd0);
        a_zero    = (a[30:23] == 8'd0);
        b_zero    = (b[30:23] == 8'd0);
        x         = a;
        y         = b;
        r         = FLOAT_ZERO;
        ed        = 8'd0;
        mx        = 27'd0;
        my        = 27'd0;
        my_sh     = 27'd0;
        lost_mask = 27'd0;
        s         = 28'd0;
        e         = 10'd0;
        rnd_up    = 1'b0;
        m_rnd     = 25'd0;
        frac      = 23'd0;

        if (is_nan(a) || is_nan(b)) begin
            r = FLOAT_QNAN;
        end else if (a_inf && b_inf) begin
            r = (a[31] == b[31]) ? a : FLOAT_QNAN;
        end else if (a_inf) begin
            r = a;
        end else if (b_inf) begin
            r = b;
        end else if (a_zero && b_zero) begin
            r = {a[31] & b[31], 31'd0};
        end else if (a_zero) begin
            r = b;
        end else if (b_zero) begin
            r = a;
        end else begin
            // x carries the larger magnitude and therefore the result sign
            if (b[30:0] > a[30:0]) begin
                x = b;
                y = a;
            end else begin
                x = a;
                y = b;
            end
            ed = x[30:23] - y[30:23];
            mx = {1'b1, x[22:0], 3'b000};
            my = {1'b1, y[22:0], 3'b000};
            if (ed >= 8'd27) begin
                my_sh = 27'd1;
            end else begin
                lost_mask = (27'd1 << ed) - 27'd1;
                my_sh     = (my >> ed) | {26'd0, |(my & lost_mask)};
            end
            e = {2'b00, x[30:23]};
            if (x[31] == y[31]) begin
                s = {1'b0, mx} + {1'b0, my_sh};
                if (s[27]) begin
                    s = {1'b0, s[27:2], s[1] | s[0]};
                    e = e + 10'd1;
                end else begin
                    s = s;
                end
            end else begin
                s = {1'b0, mx} - {1'b0, my_sh};
                for (int i = 0; i < 27; i++) begin
                    if ((s[26] == 1'b0) && (s != 28'd0)) begin
                        s = s << 1;
                        e = e - 10'd1;
                    end else begin
                        s = s;
                    end
                end
            end
            rnd_up = s[2] & (s[1] | s[0] | s[3]);
            m_rnd  = {1'b0, s[26:3]} + {24'd0, rnd_up};
            if (m_rnd[24]) begin
                e    = e + 10'd1;
                frac = m_rnd[23:1];
            end else begin
                frac = m_rnd[22:0];
            end
            if (s == 28'd0) begin
                r = FLOAT_ZERO;
            end else if (e[9] || (e == 10'd0)) begin
                r = {x[31], 31'd0};
            end else if (e >= 10'd255) begin
                r = {x[31], FLOAT_EXP_MAX, 23'd0};
            end else begin
                r = {x[31], e[7:0], frac};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_activation_seq_relu_lane.sv
// One element of the datapath: float bias add followed by an optional ReLU clamp.
module bias_relu_lane
    import bias_activation_seq_pkg::*;
(
    input  logic [FLOAT_W-1:0] a,
    input  logic [FLOAT_W-1:0] b,
    input  logic               relu_en,
    output logic [FLOAT_W-1:0] y
);

    logic [FLOAT_W-1:0] sum_s;

    assign sum_s = fp_add(a, b);

    // Negative sums (including -0.0) clamp to +0.0; NaN passes through untouched
    always_comb begin
        if (relu_en && sum_s[FLOAT_W-1] && !is_nan(sum_s)) begin
            y = FLOAT_ZERO;
        end else begin
            y = sum_s;
        end
    end

endmodule

// File: rtl/bias_activation_seq.sv
// Sequential bias-add / ReLU stage: captures an L x N float32 matrix on a start edge,
// processes one element per clock and holds the finished matrix with a done flag.
module bias_activation_seq
    import bias_activation_seq_pkg::*;
#(
    parameter int L = 2,
    parameter int N = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [FLOAT_W*L*N-1:0]   mat_in,
    input  logic [FLOAT_W*N-1:0]     bias,
    input  logic                     relu_en,
    output logic [FLOAT_W*L*N-1:0]   result,
    output logic                     busy,
    output logic                     done
);

    localparam int LN    = L * N;
    localparam int IDX_W = (LN > 1) ? $clog2(LN) : 1;
    localparam int COL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    logic [1:0]            state_q, state_d;
    logic                  start_q, start_d;
    logic [FLOAT_W*LN-1:0] buf_in_q, buf_in_d;
    logic [FLOAT_W*N-1:0]  buf_bias_q, buf_bias_d;
    logic                  relu_en_q, relu_en_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [FLOAT_W*LN-1:0] result_q, result_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  start_acc_s;
    logic [FLOAT_W-1:0]    lane_a_s;
    logic [FLOAT_W-1:0]    lane_b_s;
    logic [FLOAT_W-1:0]    lane_y_s;

    assign start_acc_s = start & ~start_q & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign lane_a_s    = buf_in_q[idx_q * FLOAT_W +: FLOAT_W];
    assign lane_b_s    = buf_bias_q[col_q * FLOAT_W +: FLOAT_W];

    bias_relu_lane u_lane (
        .a       (lane_a_s),
        .b       (lane_b_s),
        .relu_en (relu_en_q),
        .y       (lane_y_s)
    );

    // Next-state logic: edge-triggered launch, one element per RUN cycle
    always_comb begin
        state_d    = state_q;
        start_d    = start;
        buf_in_d   = buf_in_q;
        buf_bias_d = buf_bias_q;
        relu_en_d  = relu_en_q;
        idx_d      = idx_q;
        col_d      = col_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    buf_in_d   = mat_in;
                    buf_bias_d = bias;
                    relu_en_d  = relu_en;
                    idx_d      = '0;
                    col_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                result_d[idx_q * FLOAT_W +: FLOAT_W] = lane_y_s;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    col_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                    col_d = (col_q == COL_LAST) ? '0 : col_q + COL_ONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any run and clears the visible matrix
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            buf_in_q   <= '0;
            buf_bias_q <= '0;
            relu_en_q  <= 1'b0;
            idx_q      <= '0;
            col_q      <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            buf_in_q   <= buf_in_d;
            buf_bias_q <= buf_bias_d;
            relu_en_q  <= relu_en_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/bias_activation_seq.md
Name: bias_activation_seq

Overview:
- Sequential post-processing stage directly downstream of the matrix-multiplication units.
- Consumes the flat L x N float32 result matrix and the multiplier's done signal.
- Adds a per-column bias vector to every element and optionally applies ReLU, one element per clock.
- Presents the finished matrix with its own done flag, so it can feed the next layer's A input.

Parameters:
L, 2, number of rows in the input matrix (rows of A in the preceding multiplication)
N, 2, number of columns in the input matrix; also the bias vector length

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  connected to upstream done; the rising edge launches processing
mat_in  input  32*L*N  float32 matrix, row-major, element (r,c) at [32*(r*N+c) +: 32]
bias  input  32*N  float32 bias, element c at [32*c +: 32]
relu_en  input  1  1 = apply ReLU after bias add, 0 = bias add only
result  output  32*L*N  processed matrix, same layout as mat_in
busy  output  1  high while elements are being processed
done  output  1  high when result is valid; held until the next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, busy=0, done=0, index counter=0, start edge register=0. Asserting reset mid-run aborts immediately; no partial result survives.
- Start detection: start_q registers start each cycle. An accepted start is start & ~start_q while state is IDLE or DONE. Level-high start does not retrigger.
- On an accepted start:
  - mat_in, bias and relu_en are captured into internal buffers; later input changes have no effect on this run.
  - done drops to 0, busy rises to 1, idx=0, state=RUN.
- RUN, each cycle:
  - sum = fp_add(buf_in[idx], buf_bias[idx mod N]).
  - If relu_en_q and sum[31]=1 and sum is not NaN (exp != 8'hFF or mantissa = 0), the element written is 32'h00000000; otherwise it is sum. -0.0 therefore becomes +0.0 under ReLU, and NaN passes through unchanged.
  - result[32*idx +: 32] is written. The column counter increments and wraps at N; idx increments.
- After the cycle with idx = L*N-1, state=DONE, busy=0, done=1.
- Latency: done is high in the cycle after L*N RUN cycles. Total is L*N+1 clocks from the accepted start edge to done visible.
- A start rising edge during RUN is ignored and does not restart the run.
- result holds its value in DONE and IDLE. Only elements not yet processed in a new run keep their old values until overwritten.
- Column tracking uses a separate counter, not a divider. idx width is clog2(L*N), minimum 1.
- fp_add semantics are identical to the existing float adder: round-to-nearest-even, no denormal support beyond what that adder provides.

Decomposition:
- Shared package/header: FLOAT_W=32, FLOAT_ZERO=32'h0, FLOAT_EXP_MAX=8'hFF, and a NaN-detect function. All are reused by the later activation variants.
- One natural sub-module: bias_relu_lane. It is combinational: the existing float adder instance plus the ReLU mux, with ports a, b, relu_en, y.
- The FSM, buffers and counters stay in bias_activation_seq.

Test Plan:
- Basic run, L=2, N=2, relu_en=0: mat_in={1.0,-2.0,3.0,-4.0}, bias={0.5,1.0}, pulse start. Expect result = {3FC00000, BF800000, 40600000, C0400000} (1.5, -1.0, 3.5, -3.0). done rises exactly 5 clocks after the start edge.
- Same data with relu_en=1: expect result = {3FC00000, 00000000, 40600000, 00000000}. busy is high for exactly 4 cycles.
- ReLU zero-sign cases: mat_in element -0.5 with bias 0.5 gives +0.0. Element 7FC00000 (NaN) with any bias and relu_en=1 stays NaN.
- Start held high for 20 cycles: exactly one run. Change mat_in during RUN: the result reflects the captured values only. A second rising start edge during RUN is ignored.
- Reset mid-run (assert rst after 2 RUN cycles, asynchronous to clk edge): result=0, busy=0, done=0 immediately. A subsequent start completes normally.
- Back-to-back: the next start edge while in DONE clears done the following cycle and produces the new correct matrix. Repeat with L=1, N=3 to check column wrap and bias indexing.
